// File: rtl/time_stamp_pkg.sv
// Shared types and constants for the timestamp frame transmitter.
// Frame: "MM-DD HH:MM:SS" with an optional CR/LF trailer.
package time_stamp_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] SEP_DATE  = 8'h2D;
    localparam logic [7:0] SEP_SPACE = 8'h20;
    localparam logic [7:0] SEP_TIME  = 8'h3A;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;

    localparam int FRAME_LEN_BASE = 14;
    localparam int FRAME_LEN_CRLF = 16;

    function automatic logic [3:0] lastIndex(input bit crlfEn);
        return crlfEn ? 4'(FRAME_LEN_CRLF - 1) : 4'(FRAME_LEN_BASE - 1);
    endfunction

endpackage

// File: rtl/bin2ascii2.sv
// Converts a 6-bit binary value (0..63) into two ASCII decimal digits.
// Out-of-calendar values are converted unchanged; no clamping.
module bin2ascii2
    import time_stamp_pkg::*;
(
    input  logic [5:0] i_bin,
    output logic [7:0] o_tens,
    output logic [7:0] o_ones
);

    logic [5:0] w_tens;
    logic [5:0] w_ones;

    assign w_tens = i_bin / 6'd10;
    assign w_ones = i_bin - w_tens * 6'd10;
    assign o_tens = ASCII_0 + {2'b00, w_tens};
    assign o_ones = ASCII_0 + {2'b00, w_ones};

endmodule

// File: rtl/time_stamp_tx.sv
// Snapshots the watch time fields on a min15 edge or req edge and streams
// the ASCII timestamp frame to the UART TX over a valid/ready handshake.
module time_stamp_tx
    import time_stamp_pkg::*;
#(
    parameter bit CRLF_EN = 1'b1
) (
    input  logic       MH50,
    input  logic       rst,
    input  logic       min15,
    input  logic       req,
    input  logic [5:0] Hsec,
    input  logic [5:0] Hmin,
    input  logic [4:0] Hhour,
    input  logic [4:0] Hday,
    input  logic [3:0] Hmon,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       dropped
);

    localparam logic [3:0] LAST_IDX = lastIndex(CRLF_EN);

    state_t     r_state;
    state_t     w_stateNext;
    logic [3:0] r_idx;
    logic [3:0] w_idxNext;
    logic       w_capture;

    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync3;
    logic [1:0] r_fill;
    logic       r_armed;
    logic       r_reqDly;
    logic       r_trig;
    logic       w_minEdge;
    logic       w_reqEdge;

    logic [5:0] r_mon;
    logic [5:0] r_day;
    logic [5:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;

    logic [7:0] w_monTens, w_monOnes;
    logic [7:0] w_dayTens, w_dayOnes;
    logic [7:0] w_hourTens, w_hourOnes;
    logic [7:0] w_minTens, w_minOnes;
    logic [7:0] w_secTens, w_secOnes;
    logic [7:0] w_byte;

    // min15 edges count only once sync2 has shown a genuine low after reset,
    // so a pulse already high at reset release does not fire a frame.
    assign w_minEdge = r_sync2 & ~r_sync3 & r_armed;
    assign w_reqEdge = req & ~r_reqDly;

    always_ff @(posedge MH50) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_fill   <= 2'b00;
            r_armed  <= 1'b0;
            r_reqDly <= 1'b0;
            r_trig   <= 1'b0;
        end else begin
            r_sync1  <= min15;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_fill   <= {r_fill[0], 1'b1};
            r_armed  <= r_armed | (r_fill[1] & ~r_sync2);
            r_reqDly <= req;
            r_trig   <= w_minEdge | w_reqEdge;
        end
    end

    always_ff @(posedge MH50) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            r_mon   <= 6'd0;
            r_day   <= 6'd0;
            r_hour  <= 6'd0;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            if (w_capture) begin
                r_mon  <= {2'b00, Hmon};
                r_day  <= {1'b0, Hday};
                r_hour <= {1'b0, Hhour};
                r_min  <= Hmin;
                r_sec  <= Hsec;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_capture   = 1'b0;
        tx_valid    = 1'b0;
        busy        = 1'b0;
        dropped     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_trig) begin
                    w_capture   = 1'b1;
                    w_stateNext = SEND;
                    w_idxNext   = 4'd0;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                dropped  = r_trig;
                if (tx_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_stateNext = IDLE;
                        w_idxNext   = 4'd0;
                    end else begin
                        w_idxNext = r_idx + 4'd1;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    bin2ascii2 uMon  (.i_bin(r_mon),  .o_tens(w_monTens),  .o_ones(w_monOnes));
    bin2ascii2 uDay  (.i_bin(r_day),  .o_tens(w_dayTens),  .o_ones(w_dayOnes));
    bin2ascii2 uHour (.i_bin(r_hour), .o_tens(w_hourTens), .o_ones(w_hourOnes));
    bin2ascii2 uMin  (.i_bin(r_min),  .o_tens(w_minTens),  .o_ones(w_minOnes));
    bin2ascii2 uSec  (.i_bin(r_sec),  .o_tens(w_secTens),  .o_ones(w_secOnes));

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:    w_byte = w_monTens;
            4'd1:    w_byte = w_monOnes;
            4'd2:    w_byte = SEP_DATE;
            4'd3:    w_byte = w_dayTens;
            4'd4:    w_byte = w_dayOnes;
            4'd5:    w_byte = SEP_SPACE;
            4'd6:    w_byte = w_hourTens;
            4'd7:    w_byte = w_hourOnes;
            4'd8:    w_byte = SEP_TIME;
            4'd9:    w_byte = w_minTens;
            4'd10:   w_byte = w_minOnes;
            4'd11:   w_byte = SEP_TIME;
            4'd12:   w_byte = w_secTens;
            4'd13:   w_byte = w_secOnes;
            4'd14:   w_byte = CR;
            4'd15:   w_byte = LF;
            default: w_byte = 8'h00;
        endcase
        tx_data = (r_state == SEND) ? w_byte : 8'h00;
    end

endmodule

// File: tb/tb_time_stamp_tx.sv
// Directed bench for time_stamp_tx: one instance with CR/LF and one without,
// sharing all inputs; accepted bytes are collected and compared to text.
module tb_time_stamp_tx;

    logic       MH50;
    logic       rst;
    logic       min15;
    logic       req;
    logic [5:0] hSec;
    logic [5:0] hMin;
    logic [4:0] hHour;
    logic [4:0] hDay;
    logic [3:0] hMon;
    logic       txReady;

    logic [7:0] txDataA, txDataB;
    logic       txValidA, txValidB;
    logic       busyA, busyB;
    logic       droppedA, droppedB;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0] rxA[$];
    logic [7:0] rxB[$];
    int         dropCntA;
    int         busyCycA;
    int         busyCycB;
    logic       stallPendA;
    logic [7:0] stallDataA;

    time_stamp_tx #(.CRLF_EN(1'b1)) dutCrlf (
        .MH50(MH50), .rst(rst), .min15(min15), .req(req),
        .Hsec(hSec), .Hmin(hMin), .Hhour(hHour), .Hday(hDay), .Hmon(hMon),
        .tx_data(txDataA), .tx_valid(txValidA), .tx_ready(txReady),
        .busy(busyA), .dropped(droppedA)
    );

    time_stamp_tx #(.CRLF_EN(1'b0)) dutPlain (
        .MH50(MH50), .rst(rst), .min15(min15), .req(req),
        .Hsec(hSec), .Hmin(hMin), .Hhour(hHour), .Hday(hDay), .Hmon(hMon),
        .tx_data(txDataB), .tx_valid(txValidB), .tx_ready(txReady),
        .busy(busyB), .dropped(droppedB)
    );

    initial MH50 = 1'b0;
    always #10 MH50 = ~MH50;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sampled mid-cycle: records handshaked bytes and checks stall stability.
    always @(negedge MH50) begin
        if (txValidA && txReady) rxA.push_back(txDataA);
        if (txValidB && txReady) rxB.push_back(txDataB);
        if (droppedA) dropCntA++;
        if (busyA) busyCycA++;
        if (busyB) busyCycB++;
        if (stallPendA) begin
            checkOutput("stallValid", {31'd0, txValidA}, 32'd1);
            checkOutput("stallData", {24'd0, txDataA}, {24'd0, stallDataA});
        end
        stallPendA = txValidA && !txReady && !rst;
        stallDataA = txDataA;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge MH50);
        #1;
    endtask

    task automatic applyStimulus(input int mon, input int day, input int hour, input int mins, input int sec);
        hMon  = 4'(mon);
        hDay  = 5'(day);
        hHour = 5'(hour);
        hMin  = 6'(mins);
        hSec  = 6'(sec);
    endtask

    task automatic pulseReq();
        req = 1'b1;
        tick(1);
        req = 1'b0;
    endtask

    task automatic clearScoreboard();
        rxA.delete();
        rxB.delete();
        dropCntA = 0;
        busyCycA = 0;
        busyCycB = 0;
    endtask

    task automatic waitFrameDone(input string tag);
        int n;
        n = 0;
        while (!busyA && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "/start"}, {31'd0, busyA}, 32'd1);
        n = 0;
        while ((busyA || busyB) && n < 300) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "/end"}, {31'd0, busyA | busyB}, 32'd0);
    endtask

    task automatic checkFrame(input string tag, input string text);
        checkOutput({tag, "/lenA"}, rxA.size(), 32'd16);
        checkOutput({tag, "/lenB"}, rxB.size(), 32'd14);
        for (int i = 0; i < 14; i++) begin
            checkOutput($sformatf("%s/A[%0d]", tag, i),
                        (i < rxA.size()) ? {24'd0, rxA[i]} : 32'hFFFF_FFFF, {24'd0, text[i]});
            checkOutput($sformatf("%s/B[%0d]", tag, i),
                        (i < rxB.size()) ? {24'd0, rxB[i]} : 32'hFFFF_FFFF, {24'd0, text[i]});
        end
        checkOutput({tag, "/A[14]"}, (rxA.size() > 14) ? {24'd0, rxA[14]} : 32'hFFFF_FFFF, 32'h0D);
        checkOutput({tag, "/A[15]"}, (rxA.size() > 15) ? {24'd0, rxA[15]} : 32'hFFFF_FFFF, 32'h0A);
    endtask

    initial begin
        int  n;
        int  holdCnt;
        bit  seenBusy;
        bit  done;

        rst = 1'b1; min15 = 1'b0; req = 1'b0; txReady = 1'b1;
        stallPendA = 1'b0; stallDataA = 8'h00;
        applyStimulus(0, 0, 0, 0, 0);
        clearScoreboard();
        tick(3);
        checkOutput("reset/txValid", {31'd0, txValidA}, 32'd0);
        checkOutput("reset/txData", {24'd0, txDataA}, 32'h00);
        checkOutput("reset/busy", {31'd0, busyA}, 32'd0);
        checkOutput("reset/dropped", {31'd0, droppedA}, 32'd0);
        rst = 1'b0;
        tick(6);

        // Basic frame with req latency.
        clearScoreboard();
        applyStimulus(3, 15, 9, 5, 42);
        pulseReq();
        checkOutput("basic/busyEdgeK", {31'd0, busyA}, 32'd0);
        tick(1);
        checkOutput("basic/validEdgeK1", {31'd0, txValidA}, 32'd1);
        checkOutput("basic/firstByte", {24'd0, txDataA}, 32'h30);
        waitFrameDone("basic");
        checkFrame("basic", "03-15 09:05:42");
        checkOutput("basic/cyclesA", busyCycA, 32'd16);
        checkOutput("basic/cyclesB", busyCycB, 32'd14);
        checkOutput("basic/noDrop", dropCntA, 32'd0);
        tick(2);

        // Backpressure: alternating ready plus a 5-cycle hold at byte 7.
        clearScoreboard();
        applyStimulus(12, 1, 23, 59, 7);
        pulseReq();
        holdCnt = 0; seenBusy = 1'b0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick(1);
            if (busyA) seenBusy = 1'b1;
            if (seenBusy && !busyA && !busyB) done = 1'b1;
            else if (txValidA && rxA.size() == 7 && holdCnt < 5) begin
                txReady = 1'b0;
                holdCnt++;
            end else begin
                txReady = ~txReady;
            end
        end
        txReady = 1'b1;
        checkOutput("bp/done", {31'd0, done}, 32'd1);
        checkOutput("bp/holdCycles", holdCnt, 32'd5);
        checkFrame("bp", "12-01 23:59:07");
        tick(2);

        // Trigger while busy is dropped.
        clearScoreboard();
        applyStimulus(1, 2, 3, 4, 5);
        pulseReq();
        tick(4);
        pulseReq();
        waitFrameDone("drop");
        tick(5);
        checkOutput("drop/count", dropCntA, 32'd1);
        checkOutput("drop/oneFrame", busyCycA, 32'd16);
        checkFrame("drop", "01-02 03:04:05");

        // min15 and req edges land in the same cycle.
        clearScoreboard();
        applyStimulus(10, 20, 12, 34, 56);
        min15 = 1'b1;
        tick(2);
        pulseReq();
        waitFrameDone("simul");
        tick(5);
        checkOutput("simul/noDrop", dropCntA, 32'd0);
        checkOutput("simul/oneFrame", busyCycA, 32'd16);
        checkFrame("simul", "10-20 12:34:56");
        min15 = 1'b0;
        tick(6);

        // Reset mid-frame.
        clearScoreboard();
        applyStimulus(4, 5, 6, 7, 8);
        pulseReq();
        n = 0;
        while (rxA.size() < 5 && n < 40) begin
            tick(1);
            n++;
        end
        checkOutput("rst/reachByte5", rxA.size(), 32'd5);
        rst = 1'b1;
        tick(1);
        checkOutput("rst/txValid", {31'd0, txValidA}, 32'd0);
        checkOutput("rst/txData", {24'd0, txDataA}, 32'h00);
        checkOutput("rst/busy", {31'd0, busyA}, 32'd0);
        checkOutput("rst/txValidB", {31'd0, txValidB}, 32'd0);
        rst = 1'b0;
        tick(20);
        checkOutput("rst/noResume", rxA.size(), 32'd6);
        checkOutput("rst/idle", {31'd0, busyA}, 32'd0);

        // min15 held high through reset release.
        clearScoreboard();
        min15 = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(12);
        checkOutput("syncRst/noFrame", busyCycA, 32'd0);
        checkOutput("syncRst/noBytes", rxA.size(), 32'd0);
        min15 = 1'b0;
        tick(6);

        // Boundary values.
        clearScoreboard();
        applyStimulus(15, 31, 31, 63, 63);
        pulseReq();
        waitFrameDone("bound");
        checkFrame("bound", "15-31 31:63:63");
        checkOutput("bound/cyclesB", busyCycB, 32'd14);
        tick(2);

        // All zeros.
        clearScoreboard();
        applyStimulus(0, 0, 0, 0, 0);
        pulseReq();
        waitFrameDone("zero");
        checkFrame("zero", "00-00 00:00:00");
        tick(2);

        // Snapshot isolation: fields churn every cycle after capture.
        clearScoreboard();
        applyStimulus(7, 8, 9, 10, 11);
        pulseReq();
        tick(1);
        checkOutput("snap/busy", {31'd0, busyA}, 32'd1);
        for (int c = 0; c < 100; c++) begin
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 63), $urandom_range(0, 63));
            tick(1);
            if (!busyA && !busyB) break;
        end
        checkOutput("snap/end", {31'd0, busyA}, 32'd0);
        checkFrame("snap", "07-08 09:10:11");
        tick(2);

        // min15 latency: tx_valid from the third edge.
        clearScoreboard();
        applyStimulus(11, 30, 23, 45, 0);
        min15 = 1'b1;
        tick(3);
        checkOutput("m15/validK2", {31'd0, txValidA}, 32'd0);
        tick(1);
        checkOutput("m15/validK3", {31'd0, txValidA}, 32'd1);
        waitFrameDone("m15");
        checkFrame("m15", "11-30 23:45:00");
        min15 = 1'b0;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
